// File: rtl/control_sequencer.sv
// control_sequencer: hardwired fetch/decode/execute step sequencer driving every datapath strobe.
// Optional feature: `define MEM_WAIT_EN adds a wait step W after every Read step.
module control_sequencer #(
    parameter int CLR_CYCLES = 1,
    parameter int OP_HI      = 31
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [31:0] IR,
    input  logic        CON_FF,
    input  logic        Stop,
    output logic        Gra, Grb, Grc, Rin, Rout, BAout, R15in,
    output logic        PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout,
    output logic        PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, Out_Portin,
    output logic        IncPC, Read, Write,
    output logic        Clear,
    output logic        Run
);
    // T0..T7 encode as 0..7 so the step number is the low three state bits
    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_RST, S_HALT, S_W1, S_W6
    } state_t;

    state_t     r_state, w_next, w_end;
    logic [4:0] r_op, w_ir_op;
    logic [3:0] r_cnt;
    logic [2:0] w_last;
    logic       w_ba, w_ldst, w_alu, w_3op, w_md, w_nn, w_unused;

    assign w_unused = ^IR;
    assign w_ir_op  = IR[OP_HI -: 5];
    assign w_ba     = r_op <= 5'd2;
    assign w_ldst   = r_op == 5'd0 || r_op == 5'd2;
    assign w_alu    = r_op >= 5'd3 && r_op <= 5'd10;
    assign w_3op    = r_op <= 5'd13;
    assign w_md     = r_op == 5'd14 || r_op == 5'd15;
    assign w_nn     = r_op == 5'd16 || r_op == 5'd17;
    assign w_last   = (r_op == 5'd1) ? 3'd5 : (r_op <= 5'd2) ? 3'd7 : (r_op <= 5'd13) ? 3'd5 :
                      (r_op <= 5'd15 || r_op == 5'd18) ? 3'd6 :
                      (r_op <= 5'd17 || r_op == 5'd20) ? 3'd4 : 3'd3;
    assign Clear    = r_state == S_RST;
    assign Run      = r_state != S_RST && r_state != S_HALT;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= S_RST;
            r_cnt   <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == S_RST) ? r_cnt + 4'd1 : '0;
            if (r_state == S_T2)
                r_op <= w_ir_op;
        end
    end

    always_comb begin
        w_end  = Stop ? S_HALT : S_T0;
        w_next = r_state;
        case (r_state)
            S_RST:   w_next = (r_cnt == 4'(CLR_CYCLES - 1)) ? S_T0 : S_RST;
            S_HALT:  w_next = S_HALT;
`ifdef MEM_WAIT_EN
            S_T1:    w_next = S_W1;
            S_W1:    w_next = S_T2;
            S_W6:    w_next = S_T7;
`endif
            S_T2:    w_next = (w_ir_op == 5'd26) ? S_HALT : (w_ir_op >= 5'd25) ? w_end : S_T3;
            default: w_next = (r_state[2:0] == w_last) ? w_end : state_t'(r_state + 4'd1);
        endcase
`ifdef MEM_WAIT_EN
        if (r_state == S_T6 && r_op == 5'd0)
            w_next = S_W6;
`endif
    end

    always_comb begin
        {Gra, Grb, Grc, Rin, Rout, BAout, R15in, PCout, MDRout, Zhighout, Zlowout, HIout, LOout,
         InPortout, Cout, PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, Out_Portin,
         IncPC, Read, Write} = '0;
        case (r_state)
            S_T0:       {PCout, MARin, IncPC, Zin} = 4'b1111;
            S_T1:       {Zlowout, PCin, Read, MDRin} = 4'b1111;
            S_W1, S_W6: {Read, MDRin} = 2'b11;
            S_T2:       {MDRout, IRin} = 2'b11;
            S_T3: begin
                if (w_3op) begin
                    {Grb, Yin} = 2'b11;
                    Rout  = !w_ba;
                    BAout = w_ba;
                end
                else if (w_md)          {Gra, Rout, Yin} = 3'b111;
                else if (w_nn)          {Grb, Rout, Zin} = 3'b111;
                else if (r_op == 5'd18) {Gra, Rout, CONin} = 3'b111;
                else if (r_op == 5'd19) {Gra, Rout, PCin} = 3'b111;
                else if (r_op == 5'd20) {PCout, R15in} = 2'b11;
                else if (r_op == 5'd21) {InPortout, Gra, Rin} = 3'b111;
                else if (r_op == 5'd22) {Gra, Rout, Out_Portin} = 3'b111;
                else if (r_op == 5'd23) {HIout, Gra, Rin} = 3'b111;
                else if (r_op == 5'd24) {LOout, Gra, Rin} = 3'b111;
            end
            S_T4: begin
                if (w_3op) begin
                    Zin  = 1'b1;
                    Grc  = w_alu;
                    Rout = w_alu;
                    Cout = !w_alu;
                end
                else if (w_md)          {Grb, Rout, Zin} = 3'b111;
                else if (w_nn)          {Zlowout, Gra, Rin} = 3'b111;
                else if (r_op == 5'd18) {PCout, Yin} = 2'b11;
                else if (r_op == 5'd20) {Gra, Rout, PCin} = 3'b111;
            end
            S_T5: begin
                if (w_3op) begin
                    Zlowout = 1'b1;
                    MARin   = w_ldst;
                    Gra     = !w_ldst;
                    Rin     = !w_ldst;
                end
                else if (w_md)          {Zlowout, LOin} = 2'b11;
                else if (r_op == 5'd18) {Cout, Zin} = 2'b11;
            end
            S_T6: begin
                if (r_op == 5'd0)       {Read, MDRin} = 2'b11;
                else if (r_op == 5'd2)  {Gra, Rout, MDRin} = 3'b111;
                else if (w_md)          {Zhighout, HIin} = 2'b11;
                else if (r_op == 5'd18) begin
                    Zlowout = 1'b1;
                    PCin    = CON_FF;
                end
            end
            S_T7: begin
                if (r_op == 5'd0)       {MDRout, Gra, Rin} = 3'b111;
                else                    Write = r_op == 5'd2;
            end
            default: ;
        endcase
    end
endmodule
